// File: rtl/axil_master_pkg.sv
// -----------------------------------------------------------------------------
// axil_master_pkg
// Shared definitions for the AXI4-Lite master engine:
//   - state_e      : engine FSM states
//   - RESP_*       : AXI4-Lite BRESP/RRESP encodings
//   - DATA_WIDTH   : AXI data bus width (fixed at 32 for AXI4-Lite here)
//   - STRB_WIDTH   : byte strobe width matching DATA_WIDTH
// -----------------------------------------------------------------------------
package axil_master_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WADDR = 3'd1,   // AW and W channels issued together
      ST_WRESP = 3'd2,
      ST_RADDR = 3'd3,
      ST_RDATA = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

endpackage

// File: rtl/axil_master_engine.sv
// -----------------------------------------------------------------------------
// axil_master_engine
// Turns single read/write commands into AXI4-Lite transfers, one at a time,
// and returns the slave's response (or a timeout abort) on a response port.
//
// Parameters
//   ADDR_WIDTH     : AXI byte address width (>= 3)
//   TIMEOUT_CYCLES : cycles allowed per handshake phase, 0 = never time out
//
// Ports
//   ACLK, ARESET            : clock, asynchronous active-high reset
//   cmd_*                   : command request (valid/ready, write, addr, data, strb)
//   rsp_*                   : response (valid/ready, rdata, resp, timeout flag)
//   M_AXI_AW*/W*/B*         : AXI4-Lite write channels
//   M_AXI_AR*/R*            : AXI4-Lite read channels
// All outputs are registered.
// -----------------------------------------------------------------------------
module axil_master_engine
   import axil_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  ACLK,
   input  logic                  ARESET,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,

   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   input  logic [1:0]            M_AXI_BRESP,
   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,

   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY
);

   // The counter only needs to reach TIMEOUT_CYCLES-1: the phase is aborted
   // at the end of the TIMEOUT_CYCLES-th cycle spent waiting in it.
   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e                  state_q;
   logic [CNT_W-1:0]        cnt_q;

   logic                    cmd_ready_q;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic [1:0]              rsp_resp_q;
   logic                    rsp_timeout_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [ADDR_WIDTH-1:0]   araddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]   wstrb_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    bready_q;
   logic                    arvalid_q;
   logic                    rready_q;

   logic [ADDR_WIDTH-1:0]   cmd_addr_aligned;
   logic                    aw_done;
   logic                    w_done;
   logic                    in_wait;
   logic                    phase_done;
   logic                    abort;

   assign cmd_addr_aligned = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};

   // A channel is finished once its VALID has dropped, or it handshakes now.
   assign aw_done = !awvalid_q || M_AXI_AWREADY;
   assign w_done  = !wvalid_q  || M_AXI_WREADY;

   always_comb begin
      phase_done = 1'b0;
      in_wait    = 1'b0;
      case (state_q)
         ST_WADDR: begin in_wait = 1'b1; phase_done = aw_done && w_done; end
         ST_WRESP: begin in_wait = 1'b1; phase_done = M_AXI_BVALID;      end
         ST_RADDR: begin in_wait = 1'b1; phase_done = M_AXI_ARREADY;     end
         ST_RDATA: begin in_wait = 1'b1; phase_done = M_AXI_RVALID;      end
         default:  ;
      endcase
   end

   // Completing the phase on the last allowed cycle wins over the abort.
   assign abort = TO_EN && in_wait && !phase_done && (cnt_q == CNT_LAST);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= RESP_OKAY;
         rsp_timeout_q <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
      end else begin
         // Counter restarts on every state change; transitions below clear it.
         if (in_wait) cnt_q <= cnt_q + 1'b1;
         else         cnt_q <= '0;

         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  awaddr_q    <= cmd_addr_aligned;
                  araddr_q    <= cmd_addr_aligned;
                  wdata_q     <= cmd_wdata;
                  wstrb_q     <= cmd_wstrb;
                  if (cmd_write) begin
                     state_q   <= ST_WADDR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                  end else begin
                     state_q   <= ST_RADDR;
                     arvalid_q <= 1'b1;
                  end
               end else begin
                  // Also raises cmd_ready on the first edge after reset.
                  cmd_ready_q <= 1'b1;
               end
            end

            ST_WADDR: begin
               if (M_AXI_AWREADY) awvalid_q <= 1'b0;
               if (M_AXI_WREADY)  wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  state_q  <= ST_WRESP;
                  bready_q <= 1'b1;
                  cnt_q    <= '0;
               end
            end

            ST_WRESP: begin
               if (M_AXI_BVALID) begin
                  state_q       <= ST_RESP;
                  bready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_resp_q    <= M_AXI_BRESP;
                  rsp_rdata_q   <= '0;
                  rsp_timeout_q <= 1'b0;
                  cnt_q         <= '0;
               end
            end

            ST_RADDR: begin
               if (M_AXI_ARREADY) begin
                  state_q   <= ST_RDATA;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
               end
            end

            ST_RDATA: begin
               if (M_AXI_RVALID) begin
                  state_q       <= ST_RESP;
                  rready_q      <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  rsp_resp_q    <= M_AXI_RRESP;
                  rsp_rdata_q   <= M_AXI_RDATA;
                  rsp_timeout_q <= 1'b0;
                  cnt_q         <= '0;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  state_q     <= ST_IDLE;
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         // Hung slave: withdraw every VALID/READY and report a timeout.
         if (abort) begin
            state_q       <= ST_RESP;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b1;
            cnt_q         <= '0;
         end
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign M_AXI_AWADDR  = awaddr_q;
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARADDR  = araddr_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_engine.sv
module tb_axil_master_engine;
   import axil_master_pkg::*;

   localparam int AW = 4;
   localparam int TO = 16;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
   logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0]   M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]    M_AXI_WSTRB;
   logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
   logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic          M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   axil_master_engine #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   // ---------------- scoreboard / counters ----------------
   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;
   exp_t sb_q[$];
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_cyc = 0;
   int arv_cycles = 0;
   always @(posedge ACLK) cyc <= cyc + 1;
   always @(negedge ACLK) if (M_AXI_ARVALID) arv_cycles <= arv_cycles + 1;

   // ---------------- AXI4-Lite slave model ----------------
   int          aw_wait = 0, w_wait = 0;
   bit          slv_no_ar = 0, slv_b_stall = 0;
   logic [1:0]  slv_bresp = RESP_OKAY, slv_rresp = RESP_OKAY;
   logic [31:0] mem [4];
   int          aw_cnt, w_cnt, aw_hs_n, w_hs_n;
   logic        aw_got, w_got;
   logic [AW-1:0] aw_addr_s;
   logic [31:0] w_data_s;
   logic [3:0]  w_strb_s;
   logic        aw_hs, w_hs;
   logic [AW-1:0] eff_addr;
   logic [31:0] eff_data;
   logic [3:0]  eff_strb;

   assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_wait);
   assign M_AXI_WREADY  = M_AXI_WVALID  && (w_cnt  >= w_wait);
   assign M_AXI_ARREADY = M_AXI_ARVALID && !slv_no_ar;
   assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs     = M_AXI_WVALID  && M_AXI_WREADY;
   assign eff_addr = aw_hs ? M_AXI_AWADDR : aw_addr_s;
   assign eff_data = w_hs  ? M_AXI_WDATA  : w_data_s;
   assign eff_strb = w_hs  ? M_AXI_WSTRB  : w_strb_s;

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_cnt <= 0; w_cnt <= 0; aw_hs_n <= 0; w_hs_n <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
         M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
         M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
      end else begin
         aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
         w_cnt  <= (M_AXI_WVALID  && !M_AXI_WREADY)  ? w_cnt + 1  : 0;
         if (aw_hs) begin aw_got <= 1'b1; aw_addr_s <= M_AXI_AWADDR; aw_hs_n <= aw_hs_n + 1; end
         if (w_hs)  begin w_got <= 1'b1; w_data_s <= M_AXI_WDATA; w_strb_s <= M_AXI_WSTRB; w_hs_n <= w_hs_n + 1; end
         if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
         if ((aw_got || aw_hs) && (w_got || w_hs) && !M_AXI_BVALID && !slv_b_stall) begin
            for (int b = 0; b < 4; b++)
               if (eff_strb[b]) mem[eff_addr[3:2]][b*8 +: 8] <= eff_data[b*8 +: 8];
            M_AXI_BVALID <= 1'b1;
            M_AXI_BRESP  <= slv_bresp;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end
         if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
         if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_RVALID <= 1'b1;
            M_AXI_RDATA  <= mem[M_AXI_ARADDR[3:2]];
            M_AXI_RRESP  <= slv_rresp;
         end
      end
   end

   // ---------------- drivers (no comparisons) ----------------
   task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] d,
                           input logic [3:0] s, output bit ok);
      ok = 1'b0;
      cmd_write = wr; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (cmd_ready) begin acc_cyc = cyc; ok = 1'b1; break; end
         @(negedge ACLK);
      end
      @(negedge ACLK);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit got, output logic [31:0] rd, output logic [1:0] rs,
                           output logic tmo, output int lat);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) begin got = 1'b1; break; end
         @(negedge ACLK);
      end
      rd = rsp_rdata; rs = rsp_resp; tmo = rsp_timeout; lat = cyc - acc_cyc;
   endtask

   task automatic ack_rsp();
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ARESET = 1'b1;
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;
      repeat (3) @(negedge ACLK);
      total++;
      if ({cmd_ready, rsp_valid, rsp_timeout, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
           M_AXI_ARVALID, M_AXI_RREADY} !== 8'h00) begin
         bad++; $display("FAIL reset_ctrl got=%b want=00000000", {cmd_ready, rsp_valid, rsp_timeout,
            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
      end
      total++;
      if ({rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB} !== '0) begin
         bad++; $display("FAIL reset_data rdata=%h resp=%b awaddr=%h araddr=%h wdata=%h wstrb=%h want all 0",
            rsp_rdata, rsp_resp, M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB);
      end
      ARESET = 1'b0;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_release_ready got=%b want=0", cmd_ready); end
      @(negedge ACLK);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_first_edge_ready got=%b want=1", cmd_ready); end
      $display("reset: cmd_ready=%b after first edge", cmd_ready);
   endtask

   task automatic test_write_zero_wait();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back('{rdata: 32'h0, resp: RESP_OKAY, tmo: 1'b0});
         send_cmd(1'b1, 4'(i * 4), 32'(i + 1), 4'hF, ok);
         wait_rsp(got, rd, rs, tmo, lat);
         e = sb_q.pop_front();
         total++;
         if (!ok || !got) begin bad++; $display("FAIL wr%0d_handshake accepted=%0d rsp=%0d want 1/1", i, ok, got); end
         total++;
         if (lat != 3) begin bad++; $display("FAIL wr%0d_latency got=%0d want=3", i, lat); end
         total++;
         if (rs !== e.resp || rd !== e.rdata || tmo !== e.tmo) begin
            bad++; $display("FAIL wr%0d_rsp resp=%b rdata=%h tmo=%b want %b/%h/%b", i, rs, rd, tmo, e.resp, e.rdata, e.tmo);
         end
         $display("write addr=%h data=%h resp=%b lat=%0d", 4'(i * 4), 32'(i + 1), rs, lat);
         ack_rsp();
      end
   endtask

   task automatic test_read_back();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      logic [AW-1:0] addrs [5];
      logic [31:0]   vals [5];
      addrs = '{4'h0, 4'h4, 4'h8, 4'hC, 4'hE};   // 0xE must read the word at 0xC
      vals  = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h4};
      for (int i = 0; i < 5; i++) begin
         sb_q.push_back('{rdata: vals[i], resp: RESP_OKAY, tmo: 1'b0});
         send_cmd(1'b0, addrs[i], 32'h0, 4'h0, ok);
         wait_rsp(got, rd, rs, tmo, lat);
         e = sb_q.pop_front();
         total++;
         if (!ok || !got) begin bad++; $display("FAIL rd%0d_handshake accepted=%0d rsp=%0d want 1/1", i, ok, got); end
         total++;
         if (lat != 3) begin bad++; $display("FAIL rd%0d_latency got=%0d want=3", i, lat); end
         total++;
         if (rd !== e.rdata || rs !== e.resp || tmo !== e.tmo) begin
            bad++; $display("FAIL rd%0d_rsp rdata=%h resp=%b tmo=%b want %h/%b/%b", i, rd, rs, tmo, e.rdata, e.resp, e.tmo);
         end
         $display("read addr=%h rdata=%h resp=%b lat=%0d", addrs[i], rd, rs, lat);
         ack_rsp();
      end
   endtask

   task automatic test_aw_w_order();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      int aw0, w0;
      int aww [3];
      int ww [3];
      aww = '{3, 0, 2};
      ww  = '{0, 3, 2};
      for (int k = 0; k < 3; k++) begin
         aw_wait = aww[k]; w_wait = ww[k];
         aw0 = aw_hs_n; w0 = w_hs_n;
         sb_q.push_back('{rdata: 32'h0, resp: RESP_OKAY, tmo: 1'b0});
         send_cmd(1'b1, 4'h0, 32'hA0 + 32'(k), 4'hF, ok);
         wait_rsp(got, rd, rs, tmo, lat);
         e = sb_q.pop_front();
         total++;
         if (!got || rs !== e.resp || rd !== e.rdata || tmo !== e.tmo) begin
            bad++; $display("FAIL order%0d_rsp got=%0d resp=%b rdata=%h tmo=%b want 1/%b/%h/%b", k, got, rs, rd, tmo, e.resp, e.rdata, e.tmo);
         end
         ack_rsp();
         repeat (3) @(negedge ACLK);
         total++;
         if (aw_hs_n - aw0 != 1 || w_hs_n - w0 != 1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL order%0d_count aw_hs=%0d w_hs=%0d rsp_valid=%b want 1/1/0", k, aw_hs_n - aw0, w_hs_n - w0, rsp_valid);
         end
         aw_wait = 0; w_wait = 0;
         sb_q.push_back('{rdata: 32'hA0 + 32'(k), resp: RESP_OKAY, tmo: 1'b0});
         send_cmd(1'b0, 4'h0, 32'h0, 4'h0, ok);
         wait_rsp(got, rd, rs, tmo, lat);
         e = sb_q.pop_front();
         total++;
         if (!got || rd !== e.rdata) begin bad++; $display("FAIL order%0d_data got=%h want=%h", k, rd, e.rdata); end
         $display("order aw_wait=%0d w_wait=%0d readback=%h", aww[k], ww[k], rd);
         ack_rsp();
      end
   endtask

   task automatic test_addr_strobe();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      sb_q.push_back('{rdata: 32'h0, resp: RESP_OKAY, tmo: 1'b0});
      send_cmd(1'b1, 4'hB, 32'hCAFE_0003, 4'hF, ok);
      wait_rsp(got, rd, rs, tmo, lat); e = sb_q.pop_front(); ack_rsp();
      sb_q.push_back('{rdata: 32'h0, resp: RESP_OKAY, tmo: 1'b0});
      send_cmd(1'b1, 4'hA, 32'h1111_2222, 4'b0011, ok);
      wait_rsp(got, rd, rs, tmo, lat); e = sb_q.pop_front(); ack_rsp();
      sb_q.push_back('{rdata: 32'hCAFE_2222, resp: RESP_OKAY, tmo: 1'b0});
      send_cmd(1'b0, 4'h9, 32'h0, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      e = sb_q.pop_front();
      total++;
      if (!got || rd !== e.rdata || rs !== e.resp) begin
         bad++; $display("FAIL align_strobe rdata=%h resp=%b want %h/%b", rd, rs, e.rdata, e.resp);
      end
      $display("align/strobe read 0x9 rdata=%h", rd);
      ack_rsp();
   endtask

   task automatic test_rsp_hold();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      sb_q.push_back('{rdata: 32'h2, resp: RESP_OKAY, tmo: 1'b0});
      send_cmd(1'b0, 4'h4, 32'h0, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge ACLK);
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_resp !== rs || rsp_timeout !== tmo || cmd_ready !== 1'b0) begin
            bad++; $display("FAIL hold%0d valid=%b rdata=%h resp=%b tmo=%b cmd_ready=%b want 1/%h/%b/%b/0",
               c, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready, rd, rs, tmo);
         end
      end
      e = sb_q.pop_front();
      total++;
      if (!got || rd !== e.rdata || rs !== e.resp || tmo !== e.tmo) begin
         bad++; $display("FAIL hold_rsp rdata=%h resp=%b tmo=%b want %h/%b/%b", rd, rs, tmo, e.rdata, e.resp, e.tmo);
      end
      ack_rsp();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL hold_release cmd_ready=%b want=1", cmd_ready); end
      $display("hold read rdata=%h held 5 cycles", rd);
   endtask

   task automatic test_slave_err();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      slv_bresp = RESP_SLVERR;
      sb_q.push_back('{rdata: 32'h0, resp: RESP_SLVERR, tmo: 1'b0});
      send_cmd(1'b1, 4'hC, 32'h99, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      e = sb_q.pop_front();
      total++;
      if (!got || rs !== e.resp || rd !== e.rdata || tmo !== e.tmo) begin
         bad++; $display("FAIL slverr_wr resp=%b rdata=%h tmo=%b want %b/%h/%b", rs, rd, tmo, e.resp, e.rdata, e.tmo);
      end
      ack_rsp();
      slv_bresp = RESP_OKAY; slv_rresp = RESP_DECERR;
      sb_q.push_back('{rdata: 32'h4, resp: RESP_DECERR, tmo: 1'b0});
      send_cmd(1'b0, 4'hC, 32'h0, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      e = sb_q.pop_front();
      total++;
      if (!got || rs !== e.resp || rd !== e.rdata || tmo !== e.tmo) begin
         bad++; $display("FAIL decerr_rd resp=%b rdata=%h tmo=%b want %b/%h/%b", rs, rd, tmo, e.resp, e.rdata, e.tmo);
      end
      $display("error passthrough read resp=%b rdata=%h", rs, rd);
      ack_rsp();
      slv_rresp = RESP_OKAY;
   endtask

   task automatic test_timeout();
      bit ok, got; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e; int arv0;
      slv_no_ar = 1'b1;
      arv0 = arv_cycles;
      sb_q.push_back('{rdata: 32'h0, resp: 2'b10, tmo: 1'b1});
      send_cmd(1'b0, 4'h8, 32'h0, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      e = sb_q.pop_front();
      total++;
      if (arv_cycles - arv0 != TO || M_AXI_ARVALID !== 1'b0) begin
         bad++; $display("FAIL timeout_arvalid cycles=%0d arvalid=%b want %0d/0", arv_cycles - arv0, M_AXI_ARVALID, TO);
      end
      total++;
      if (!got || lat != TO + 1) begin bad++; $display("FAIL timeout_latency got=%0d rsp=%0d want %0d", lat, got, TO + 1); end
      total++;
      if (tmo !== e.tmo || rs !== e.resp || rd !== e.rdata) begin
         bad++; $display("FAIL timeout_rsp tmo=%b resp=%b rdata=%h want %b/%b/%h", tmo, rs, rd, e.tmo, e.resp, e.rdata);
      end
      $display("timeout read tmo=%b resp=%b arvalid_cycles=%0d", tmo, rs, arv_cycles - arv0);
      ack_rsp();
      slv_no_ar = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit ok, got, in_wresp; logic [31:0] rd; logic [1:0] rs; logic tmo; int lat; exp_t e;
      slv_b_stall = 1'b1;
      send_cmd(1'b1, 4'h0, 32'h77, 4'hF, ok);
      in_wresp = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (M_AXI_BREADY) begin in_wresp = 1'b1; break; end
         @(negedge ACLK);
      end
      total++;
      if (!in_wresp) begin bad++; $display("FAIL midrst_reach_wresp bready=%b want=1", M_AXI_BREADY); end
      ARESET = 1'b1;
      #1;
      total++;
      if ({cmd_ready, rsp_valid, rsp_timeout, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
           M_AXI_ARVALID, M_AXI_RREADY} !== 8'h00 || M_AXI_AWADDR !== '0 || M_AXI_WDATA !== '0) begin
         bad++; $display("FAIL midrst_outputs ctrl=%b awaddr=%h wdata=%h want all 0", {cmd_ready, rsp_valid,
            rsp_timeout, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, M_AXI_AWADDR, M_AXI_WDATA);
      end
      @(negedge ACLK);
      slv_b_stall = 1'b0;
      ARESET = 1'b0;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst_release_ready got=%b want=0", cmd_ready); end
      @(negedge ACLK);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_first_edge_ready got=%b want=1", cmd_ready); end
      // The aborted write never completed, so word 0 keeps its earlier value.
      sb_q.push_back('{rdata: 32'hA2, resp: RESP_OKAY, tmo: 1'b0});
      send_cmd(1'b0, 4'h0, 32'h0, 4'h0, ok);
      wait_rsp(got, rd, rs, tmo, lat);
      e = sb_q.pop_front();
      total++;
      if (!got || rd !== e.rdata || rs !== e.resp || lat != 3) begin
         bad++; $display("FAIL midrst_recover rdata=%h resp=%b lat=%0d want %h/%b/3", rd, rs, lat, e.rdata, e.resp);
      end
      $display("mid-transfer reset recovered, read rdata=%h", rd);
      ack_rsp();
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_back();
      test_aw_w_order();
      test_addr_strobe();
      test_rsp_hold();
      test_slave_err();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axil_master_engine.md
AXIL_MASTER_ENGINE -- requirements
Module: axil_master_engine

Interface
REQ-001 ADDR_WIDTH, 4, AXI4-Lite address width in bits (minimum 3).
REQ-002 TIMEOUT_CYCLES, 255, per-phase handshake timeout in cycles; 0 disables the timeout.
REQ-003 ACLK  in  1  single clock; all logic rising-edge.
REQ-004 ARESET  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-009 cmd_wdata  in  32  write data.
REQ-010 cmd_wstrb  in  4  write byte strobes.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed when high with rsp_valid.
REQ-013 rsp_rdata  out  32  read data (0 for writes).
REQ-014 rsp_resp  out  2  BRESP/RRESP of the transfer.
REQ-015 rsp_timeout  out  1  transfer aborted by timeout.
REQ-016 M_AXI_AWADDR  out  ADDR_WIDTH  write address.
REQ-017 M_AXI_AWVALID  out  1  write address valid.
REQ-018 M_AXI_AWREADY  in  1  write address ready.
REQ-019 M_AXI_WDATA  out  32  write data.
REQ-020 M_AXI_WSTRB  out  4  write strobes.
REQ-021 M_AXI_WVALID  out  1  write data valid.
REQ-022 M_AXI_WREADY  in  1  write data ready.
REQ-023 M_AXI_BRESP  in  2  write response.
REQ-024 M_AXI_BVALID  in  1  write response valid.
REQ-025 M_AXI_BREADY  out  1  write response ready.
REQ-026 M_AXI_ARADDR  out  ADDR_WIDTH  read address.
REQ-027 M_AXI_ARVALID  out  1  read address valid.
REQ-028 M_AXI_ARREADY  in  1  read address ready.
REQ-029 M_AXI_RDATA  in  32  read data.
REQ-030 M_AXI_RRESP  in  2  read response.
REQ-031 M_AXI_RVALID  in  1  read data valid.
REQ-032 M_AXI_RREADY  out  1  read data ready.

Function
REQ-033 FSM states SHALL be IDLE, WADDR (AW/W phase), WRESP, RADDR, RDATA and RESP; cmd_ready SHALL be a registered output that is 1 only in IDLE; one transfer in flight at a time.
REQ-034 On command accept, the block SHALL register all cmd fields and go to WADDR if cmd_write is 1, else RADDR; AWADDR/ARADDR SHALL equal cmd_addr with bits [1:0] forced to 0.
REQ-035 In WADDR, AWVALID and WVALID SHALL both assert on the first cycle; each SHALL drop independently after its own handshake; the block SHALL go to WRESP once both have completed, including when both complete in the same cycle or in either order.
REQ-036 BREADY SHALL be high only in WRESP, and RREADY only in RDATA; ARVALID SHALL be high only in RADDR and held until ARREADY.
REQ-037 On the B or R handshake, the block SHALL capture BRESP or RRESP and RDATA (writes: rsp_rdata = 0), set rsp_timeout = 0, and go to RESP.
REQ-038 In RESP, rsp_valid SHALL be 1 with stable rsp_* until rsp_ready; the block SHALL return to IDLE on that handshake.
REQ-039 With a zero-wait slave, latency SHALL be: accept at cycle 0, AW/W or AR handshake at cycle 1, B/R at cycle 2, rsp_valid at cycle 3.
REQ-040 The timeout counter SHALL clear on every state change; if it reaches TIMEOUT_CYCLES in WADDR/WRESP/RADDR/RDATA, all AXI VALID/READY outputs SHALL drop, and the block SHALL go to RESP with rsp_timeout = 1, rsp_resp = 2'b10 and rsp_rdata = 0 (deliberate abort for a hung slave).
REQ-041 SLVERR/DECERR from the slave SHALL be passed through unchanged, with rsp_timeout = 0.

Reset
REQ-042 When ARESET is asserted, the block SHALL immediately go to IDLE and drive every output to 0, including cmd_ready, even mid-transfer; cmd_ready SHALL rise on the first ACLK edge after ARESET deasserts.

Structure
REQ-043 The package axil_master_pkg SHALL hold the state enum, the AXI response constants (OKAY, EXOKAY, SLVERR, DECERR) and DATA_WIDTH = 32.
REQ-044 The block SHALL be a single module with no sub-module.

Verification
REQ-045 Write 0x00000001..0x00000004 to 0x0/0x4/0x8/0xC on a zero-wait AXI4-Lite slave -> rsp_resp = 0 for each, and rsp_valid 3 cycles after each accept.
REQ-046 Read back 0x0..0xC -> rsp_rdata = 0x00000001..0x00000004 and rsp_resp = 0.
REQ-047 Slave asserts AWREADY 3 cycles after WREADY, then the reverse order, then both in the same cycle -> exactly one AW and one W handshake per write, and one response.
REQ-048 rsp_ready held low for 5 cycles -> rsp_* stable throughout, and cmd_ready stays 0 until the response handshake.
REQ-049 Slave never asserts ARREADY, with TIMEOUT_CYCLES = 16 -> ARVALID drops after 16 cycles, then rsp_timeout = 1 and rsp_resp = 2'b10.
REQ-050 ARESET pulsed while in WRESP -> all outputs 0 immediately, and cmd_ready = 1 one edge after release.
